// File: rtl/pipe_fifo_buf.sv
// pipe_fifo_buf: inter-stage pipeline buffer with a valid/ready handshake.
//
// First-word-fall-through FIFO of DEPTH entries. It replaces a fixed,
// always-enabled stage register, so adjacent stages back-pressure each other
// through the handshake. Whenever the buffer is empty, o_data carries BUBBLE
// (a NOP encoding), so downstream logic never acts on stale contents.
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset
//   i_valid  in   upstream offers i_data
//   i_ready  out  registered; high while occupancy < DEPTH
//   i_data   in   upstream payload
//   o_valid  out  registered; high while occupancy != 0
//   o_ready  in   downstream consumes the head this cycle
//   o_data   out  head entry when o_valid, else BUBBLE
//   flush    in   synchronous discard of all contents; beats push and pop
//   count    out  current occupancy
module pipe_fifo_buf #(
  parameter int unsigned        DATA_W = 64,
  parameter int unsigned        DEPTH  = 2,
  parameter logic [DATA_W-1:0]  BUBBLE = '0,
  localparam int unsigned       CW     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  output logic              i_ready,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              o_ready,
  output logic [DATA_W-1:0] o_data,
  input  logic              flush,
  output logic [CW-1:0]     count
);

  localparam int unsigned     PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0]   LastIdx = PW'(DEPTH - 1);
  localparam logic [CW-1:0]   DepthC  = CW'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     rp;
  logic [PW-1:0]     wp;
  logic [CW-1:0]     countNext;
  logic              push;
  logic              pop;

  // Both handshakes use only registered flags, so neither i_ready nor
  // o_valid has a combinational path from the opposite side.
  assign push = i_valid & i_ready & ~flush;
  assign pop  = o_valid & o_ready & ~flush;

  always_comb begin
    countNext = count;
    if (flush) begin
      countNext = '0;
    end else if (push && !pop) begin
      countNext = count + 1'b1;
    end else if (pop && !push) begin
      countNext = count - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      rp      <= '0;
      wp      <= '0;
      i_ready <= 1'b1;
      o_valid <= 1'b0;
    end else begin
      count   <= countNext;
      // Flags come from next-state occupancy, so a pop at full only
      // reopens i_ready on the following cycle.
      i_ready <= (countNext < DepthC);
      o_valid <= (countNext != '0);
      if (flush) begin
        rp <= '0;
        wp <= '0;
      end else begin
        // Explicit wrap: DEPTH need not be a power of two.
        if (push) begin
          wp <= (wp == LastIdx) ? '0 : wp + 1'b1;
        end
        if (pop) begin
          rp <= (rp == LastIdx) ? '0 : rp + 1'b1;
        end
      end
    end
  end

  // Storage is deliberately not reset or cleared on flush; o_valid gates it.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wp] <= i_data;
    end
  end

  assign o_data = o_valid ? mem[rp] : BUBBLE;

endmodule
